// File: rtl/auction_seq.sv
// Sequential sealed-bid collector: accepts one bid per bidder, then scans the
// bid table serially and hands out the highest bid (lowest index on ties).
module auction_seq #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bid_valid,
  output logic                 bid_ready,
  input  logic [N-1:0]         bid_id,
  input  logic [W-1:0]         bid_value,
  input  logic                 close,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [N-1:0]         winner,
  output logic [W-1:0]         winning_bid,
  output logic                 no_bids,
  output logic                 dup_err,
  output logic [(2**N)*W-1:0]  bid
);

  localparam int unsigned NB = 2 ** N;

  typedef enum logic [1:0] {StOpen, StScan, StResult} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   table_q [NB];
  logic [W-1:0]   table_d [NB];
  logic [NB-1:0]  has_bid_q, has_bid_d;
  logic           dup_q, dup_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [N-1:0]   best_id_q, best_id_d;
  logic [W-1:0]   best_val_q, best_val_d;
  logic           scan_last;

  // Scan index is exactly N bits; the all-ones value marks the final entry.
  assign scan_last = &idx_q;

  always_comb begin
    state_d    = state_q;
    table_d    = table_q;
    has_bid_d  = has_bid_q;
    dup_d      = dup_q;
    idx_d      = idx_q;
    best_id_d  = best_id_q;
    best_val_d = best_val_q;
    unique case (state_q)
      StOpen: begin
        if (bid_valid) begin
          if (has_bid_q[bid_id]) begin
            dup_d = 1'b1;
          end else begin
            table_d[bid_id]   = bid_value;
            has_bid_d[bid_id] = 1'b1;
          end
        end
        if (close) begin
          state_d = StScan;
          idx_d   = '0;
        end
      end
      StScan: begin
        // Strict compare keeps the earliest (lowest-index) maximum.
        if ((idx_q == '0) || (table_q[idx_q] > best_val_q)) begin
          best_id_d  = idx_q;
          best_val_d = table_q[idx_q];
        end
        if (scan_last) begin
          state_d = StResult;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StResult: begin
        if (result_ready) begin
          state_d   = StOpen;
          table_d   = '{default: '0};
          has_bid_d = '0;
          dup_d     = 1'b0;
        end
      end
      default: state_d = StOpen;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StOpen;
      table_q    <= '{default: '0};
      has_bid_q  <= '0;
      dup_q      <= 1'b0;
      idx_q      <= '0;
      best_id_q  <= '0;
      best_val_q <= '0;
    end else begin
      state_q    <= state_d;
      table_q    <= table_d;
      has_bid_q  <= has_bid_d;
      dup_q      <= dup_d;
      idx_q      <= idx_d;
      best_id_q  <= best_id_d;
      best_val_q <= best_val_d;
    end
  end

  always_comb begin
    bid_ready    = (state_q == StOpen);
    result_valid = (state_q == StResult);
    no_bids      = result_valid & ~(|has_bid_q);
    winner       = '0;
    winning_bid  = '0;
    if (result_valid && !no_bids) begin
      winner      = best_id_q;
      winning_bid = best_val_q;
    end
    dup_err = dup_q;
  end

  always_comb begin
    bid = '0;
    for (int i = 0; i < NB; i++) begin
      bid[i*W +: W] = table_q[i];
    end
  end

endmodule

// File: tb/tb_auction_seq.sv
// Directed bench for auction_seq (N=2, W=2) with hand-computed expectations.
module tb_auction_seq;

  localparam int unsigned N = 2;
  localparam int unsigned W = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           bid_valid;
  logic           bid_ready;
  logic [N-1:0]   bid_id;
  logic [W-1:0]   bid_value;
  logic           close;
  logic           result_valid;
  logic           result_ready;
  logic [N-1:0]   winner;
  logic [W-1:0]   winning_bid;
  logic           no_bids;
  logic           dup_err;
  logic [(2**N)*W-1:0] bid;

  int total = 0;
  int bad   = 0;

  auction_seq #(.N(N), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bid_valid    (bid_valid),
    .bid_ready    (bid_ready),
    .bid_id       (bid_id),
    .bid_value    (bid_value),
    .close        (close),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .winner       (winner),
    .winning_bid  (winning_bid),
    .no_bids      (no_bids),
    .dup_err      (dup_err),
    .bid          (bid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bid(input logic [N-1:0] id, input logic [W-1:0] val);
    bid_valid = 1'b1;
    bid_id    = id;
    bid_value = val;
    step();
    bid_valid = 1'b0;
  endtask

  // Pulse close, then count cycles until result_valid; 4 more edges expected.
  task automatic close_and_wait(input string tag);
    int cnt;
    close = 1'b1;
    step();
    close = 1'b0;
    cnt = 0;
    while (!result_valid && cnt < 20) begin
      step();
      cnt++;
    end
    chk({tag, "_latency"}, cnt, 4);
  endtask

  task automatic take_result();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bid_valid = 1'b0; bid_id = '0; bid_value = '0;
    close = 1'b0; result_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    chk("rst_bid_ready", bid_ready, 1);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_winner", winner, 0);
    chk("rst_winning_bid", winning_bid, 0);
    chk("rst_no_bids", no_bids, 0);
    chk("rst_dup_err", dup_err, 0);
    chk("rst_bid", bid, 0);

    // Basic auction
    send_bid(2'd0, 2'd1);
    chk("basic_bid_after_first", bid, 8'h01);
    send_bid(2'd1, 2'd3);
    send_bid(2'd2, 2'd2);
    send_bid(2'd3, 2'd0);
    close_and_wait("basic");
    chk("basic_winner", winner, 1);
    chk("basic_winning_bid", winning_bid, 3);
    chk("basic_no_bids", no_bids, 0);
    chk("basic_bid_table", bid, 8'h2D);
    chk("basic_bid_ready_low", bid_ready, 0);
    take_result();
    chk("basic_after_valid", result_valid, 0);
    chk("basic_after_ready", bid_ready, 1);
    chk("basic_after_bid", bid, 0);

    // Tie resolves to lowest index
    send_bid(2'd3, 2'd3);
    send_bid(2'd1, 2'd3);
    close_and_wait("tie");
    chk("tie_winner", winner, 1);
    chk("tie_winning_bid", winning_bid, 3);
    take_result();

    // Duplicate bid is ignored and flagged
    send_bid(2'd2, 2'd1);
    chk("dup_err_before", dup_err, 0);
    send_bid(2'd2, 2'd3);
    chk("dup_err_set", dup_err, 1);
    chk("dup_table", bid, 8'h10);
    close_and_wait("dup");
    chk("dup_winner", winner, 2);
    chk("dup_winning_bid", winning_bid, 1);
    chk("dup_err_in_result", dup_err, 1);
    take_result();
    chk("dup_err_cleared", dup_err, 0);
    chk("dup_bid_cleared", bid, 0);

    // Empty auction with held result; bids and close offered meanwhile are ignored
    close_and_wait("empty");
    chk("empty_winner", winner, 0);
    chk("empty_winning_bid", winning_bid, 0);
    chk("empty_no_bids", no_bids, 1);
    bid_valid = 1'b1; bid_id = 2'd1; bid_value = 2'd3; close = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", result_valid, 1);
      chk("hold_no_bids", no_bids, 1);
      chk("hold_winner", winner, 0);
      chk("hold_bid_ready", bid_ready, 0);
      chk("hold_bid", bid, 0);
    end
    bid_valid = 1'b0; close = 1'b0;
    take_result();
    chk("empty_after_ready", bid_ready, 1);
    chk("empty_after_no_bids", no_bids, 0);

    // Bid in the same cycle as close is included
    bid_valid = 1'b1; bid_id = 2'd0; bid_value = 2'd2;
    close_and_wait("same");
    bid_valid = 1'b0;
    chk("same_winner", winner, 0);
    chk("same_winning_bid", winning_bid, 2);
    chk("same_no_bids", no_bids, 0);
    take_result();

    // Asynchronous reset mid-scan aborts the auction
    send_bid(2'd1, 2'd2);
    send_bid(2'd1, 2'd1);
    chk("abort_dup_pre", dup_err, 1);
    close = 1'b1;
    step();
    close = 1'b0;
    step();
    chk("abort_in_scan", bid_ready, 0);
    rst = 1'b1;
    #1;
    chk("abort_bid_ready", bid_ready, 1);
    chk("abort_result_valid", result_valid, 0);
    chk("abort_dup_err", dup_err, 0);
    chk("abort_bid", bid, 0);
    chk("abort_winner", winner, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_abort_ready", bid_ready, 1);
    send_bid(2'd3, 2'd1);
    close_and_wait("fresh");
    chk("fresh_winner", winner, 3);
    chk("fresh_winning_bid", winning_bid, 1);
    chk("fresh_no_bids", no_bids, 0);
    take_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
